ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It consumes the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and operand values leaving the ID/EX pipeline register. It holds the architectural HI/LO registers and raises `busy` so the hazard logic stalls IF/ID/EX while an iterative operation runs. Both multiply and divide use a shared radix-2 shift/add–subtract datapath with a 32-iteration sequence.

## Interface
- No parameters; datapath width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `mthi`  in  1  write `wr_data` to HI.
- `mtlo`  in  1  write `wr_data` to LO.
- `wr_data`  in  32  MTHI/MTLO data.
- `hi`  out  32  architectural HI register (MFHI source).
- `lo`  out  32  architectural LO register (MFLO source).
- `busy`  out  1  operation in flight; drives the pipeline stall.
- `done`  out  1  single-cycle pulse when HI/LO are updated with a result.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 → capture operands and `op`, go to RUN, counter=0.
  - Signed ops capture absolute values and record the result signs.
- RUN:
  - One iteration per cycle; counter 0..31.
  - Multiply: 64-bit shift/add accumulator.
  - Divide: restoring shift/subtract, 64-bit remainder:quotient register.
  - After iteration 31 → FIN.
- FIN:
  - Apply sign correction, write HI/LO, assert `done`, return to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. Signed ops produce the two's-complement 64-bit product.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `rs_val` as captured. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
- MTHI/MTLO:
  - Take effect at the edge only in IDLE with `start`=0.
  - Ignored while `busy`.
  - Ignored when `start`=1 in the same cycle (`start` wins).
  - `mthi` and `mtlo` together write both registers.
- `start` while `busy`: ignored. The in-flight operation is not disturbed.
- `hi`/`lo` hold their previous values throughout RUN. There are no partial-result updates.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset in any state aborts the operation and clears all state the same edge. The result is never written.
- E0 (`start` accepted):
  - `busy`=1 from E0.
  - Operands in `rs_val`/`rt_val` are no longer needed after E0.
- E1..E32: the 32 iterations.
- E33 (FIN):
  - HI/LO updated.
  - `busy`=0.
  - `done`=1 for exactly the cycle after E33.
- `busy` is high for 33 consecutive cycles.
- A new `start` is accepted at E34 at the earliest, i.e. the cycle `done` is high.
- MTHI/MTLO latency: 1 edge. The new value is visible on `hi`/`lo` the next cycle.
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Test plan
- MULT `rs`=0xFFFFFFFD (−3), `rt`=5 → at E33 HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done` one cycle; `busy` high exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007. Then DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0xABCD in IDLE → `hi`=0x1234, `lo`=0xABCD. MTLO 0x5555 asserted mid-RUN of MULTU 3×4 → ignored; E33 gives HI=0, LO=0x0000000C.
- `start` with DIVU 100/7, then a second `start` with MULT 2×2 at cycle 10 → second ignored; result LO=14, HI=2.
- MULTU 0xFFFF×0xFFFF with `reset` at cycle 15 → next cycle `busy`=0, `hi`=`lo`=0; no `done` pulse; a new MULTU 6×7 then completes correctly (LO=42).

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
// Holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU over
// 32 cycles on a shared radix-2 shift/add (multiply) or restoring
// shift/subtract (divide) datapath. Signed operations run on magnitudes and
// the signs are applied in the FIN cycle.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic        is_div_reg;
    logic        neg_q_reg;     // negate product / quotient at FIN
    logic        neg_r_reg;     // negate remainder at FIN (dividend was negative)
    logic        div_zero_reg;
    logic [31:0] addend_reg;    // |multiplicand| or |divisor|
    logic [63:0] acc_reg;       // product accumulator or remainder:quotient
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // Operand decode at capture: op[0]=1 means unsigned, op[1]=1 means divide.
    logic        signed_op;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;

    // Per-iteration datapath values.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic        div_geq;
    logic [31:0] div_diff;
    logic [63:0] div_next;

    // Sign-corrected results presented to HI/LO in the FIN cycle.
    logic [63:0] prod_signed;
    logic [31:0] quot_signed;
    logic [31:0] rem_signed;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Operand magnitudes and signs for the capture edge.
    always_comb begin
        signed_op = ~op[0];
        rs_neg    = signed_op & rs_val[31];
        rt_neg    = signed_op & rt_val[31];
        rs_abs    = rs_neg ? (32'd0 - rs_val) : rs_val;
        rt_abs    = rt_neg ? (32'd0 - rt_val) : rt_val;
    end

    // One shift/add or shift/subtract step on the accumulator.
    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB is set,
        // then shift the 65-bit {carry, acc} right by one.
        mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, addend_reg};
        mul_next = acc_reg[0] ? {mul_sum, acc_reg[31:1]} : {1'b0, acc_reg[63:1]};
        // Divide: the shifted partial remainder is 33 bits wide ({acc[63:31]});
        // the difference always fits in 32 bits when the subtraction succeeds.
        div_geq  = {acc_reg[63:31]} >= {1'b0, addend_reg};
        div_diff = acc_reg[62:31] - addend_reg;
        div_next = div_geq ? {div_diff, acc_reg[30:0], 1'b1}
                           : {acc_reg[62:0], 1'b0};
    end

    // Sign correction and divide-by-zero override for the FIN write.
    always_comb begin
        prod_signed = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
        quot_signed = neg_q_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
        rem_signed  = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
        if (is_div_reg) begin
            res_hi = rem_signed;       // divide by zero leaves the dividend here
            res_lo = div_zero_reg ? 32'hFFFF_FFFF : quot_signed;
        end else begin
            res_hi = prod_signed[63:32];
            res_lo = prod_signed[31:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= 5'd0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            addend_reg   <= 32'd0;
            acc_reg      <= 64'd0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_RUN;
                        count_reg    <= 5'd0;
                        is_div_reg   <= op[1];
                        neg_q_reg    <= rs_neg ^ rt_neg;
                        neg_r_reg    <= rs_neg;
                        div_zero_reg <= (rt_val == 32'd0);
                        addend_reg   <= op[1] ? rt_abs : rs_abs;
                        acc_reg      <= {32'd0, (op[1] ? rs_abs : rt_abs)};
                    end else begin
                        if (mthi) hi_reg <= wr_data;
                        if (mtlo) lo_reg <= wr_data;
                    end
                end
                S_RUN: begin
                    acc_reg   <= is_div_reg ? div_next : mul_next;
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) state_reg <= S_FIN;
                end
                S_FIN: begin
                    hi_reg    <= res_hi;
                    lo_reg    <= res_lo;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed vector table, hand-written corner
// sequences and randomized operations checked against an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    ex_muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wr_data (wr_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb;
        logic [63:0] ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p = 64'd0; q = 64'd0; r = 64'd0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = ua * ub;
            2'b10: if (b != 0) begin q = sa / sb; r = sa % sb; end
            default: if (b != 0) begin q = ua / ub; r = ua % ub; end
        endcase
        if (!o[1]) begin
            h = p[63:32]; l = p[31:0];
        end else if (b == 0) begin
            h = a; l = 32'hFFFF_FFFF;
        end else begin
            h = r[31:0]; l = q[31:0];
        end
    endfunction

    // Issue one operation and follow it to completion. inj_kind 1 asserts a
    // second start (MULT 2x2) and inj_kind 2 asserts MTLO 0x5555, each for
    // one cycle at busy cycle inj_cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cycle, input int inj_kind,
                         output logic [31:0] h, output logic [31:0] l,
                         output int busy_cnt, output logic done_now, output logic done_after);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            start = 1'b0; mtlo = 1'b0;
            if (busy_cnt == inj_cycle && inj_kind == 1) begin
                start = 1'b1; op = 2'b00; rs_val = 32'd2; rt_val = 32'd2;
            end
            if (busy_cnt == inj_cycle && inj_kind == 2) begin
                mtlo = 1'b1; wr_data = 32'h5555;
            end
            @(negedge clk);
        end
        start = 1'b0; mtlo = 1'b0;
        h = hi; l = lo; done_now = done;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                                 input int inj_cycle, input int inj_kind);
        logic [31:0] h, l;
        int          bc;
        logic        d0, d1;
        do_op(o, a, b, inj_cycle, inj_kind, h, l, bc, d0, d1);
        $display("%s op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h busy_cycles=%0d", tag, o, a, b, h, l, bc);
        check({tag, " hi"}, h, eh);
        check({tag, " lo"}, l, el);
        check({tag, " busy_cycles"}, 32'(bc), 32'd33);
        check({tag, " done_pulse"}, {30'd0, d0, d1}, 32'b10);
    endtask

    initial begin
        logic [31:0] mh, ml, a, b;
        logic [1:0]  o;
        logic        saw_done;

        vectors = 0;
        miscompares = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = 32'd0;

        tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
        tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        repeat (3) @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                          tbl[i].exp_hi, tbl[i].exp_lo, 0, 0);

        // MTHI then MTLO in IDLE, each visible the following cycle.
        @(negedge clk); mthi = 1'b1; wr_data = 32'h1234;
        @(negedge clk); mthi = 1'b0;
        check("mthi hi", hi, 32'h1234);
        mtlo = 1'b1; wr_data = 32'hABCD;
        @(negedge clk); mtlo = 1'b0;
        check("mtlo lo", lo, 32'hABCD);
        check("mtlo hi_kept", hi, 32'h1234);
        $display("mthi/mtlo -> hi=0x%08h lo=0x%08h", hi, lo);

        // MTLO during RUN is ignored; second start during RUN is ignored.
        run_and_check("mtlo_mid_run", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 12, 2);
        run_and_check("start_mid_run", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1);

        // Reset part-way through an operation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'hFFFF; rt_val = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", {31'd0, saw_done}, 32'd0);
        $display("abort -> busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
        run_and_check("after_abort", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: a = $urandom_range(0, 50);
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            model(o, a, b, mh, ml);
            run_and_check($sformatf("rand%0d", i), o, a, b, mh, ml, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
